// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit that steps one instruction
// through fetch (T0..T2) and a class-dependent execute sequence (T3..T6).
// All outputs are registered from the next state and the next decode
// fields, so each output lines up with the state it belongs to and clears
// together with the state on an asynchronous clear.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] IR,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [7:0]  ctrl_in,
  output logic [7:0]  ctrl_out,
  output logic [13:0] alu_op,
  output logic        Read,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  // ctrl_in bit positions
  localparam int CI_HI  = 7;
  localparam int CI_LO  = 6;
  localparam int CI_PC  = 5;
  localparam int CI_IR  = 4;
  localparam int CI_Y   = 3;
  localparam int CI_Z   = 2;
  localparam int CI_MAR = 1;
  localparam int CI_MDR = 0;
  // ctrl_out bit positions
  localparam int CO_ZHI = 5;
  localparam int CO_ZLO = 4;
  localparam int CO_PC  = 3;
  localparam int CO_MDR = 2;
  // alu_op bit positions
  localparam int A_INCPC = 13;

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  typedef enum logic [1:0] {C_ILL, C_BIN, C_UNA, C_MD} cls_t;

  state_t      state, state_nx;
  logic [4:0]  opc, opc_nx;
  logic [3:0]  ra, rb, rc, ra_nx, rb_nx, rc_nx;
  cls_t        cls, cls_nx;

  logic [15:0] rin_nx, rout_nx;
  logic [7:0]  cin_nx, cout_nx;
  logic [13:0] alu_nx;
  logic        read_nx, busy_nx, done_nx, illegal_nx;

  // IR[14:0] carries no field this unit decodes
  logic unused_ir;
  assign unused_ir = ^IR[14:0];

  function automatic cls_t classify(input logic [4:0] o);
    case (o)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: classify = C_BIN;
      5'd17, 5'd18:                                          classify = C_UNA;
      5'd15, 5'd16:                                          classify = C_MD;
      default:                                               classify = C_ILL;
    endcase
  endfunction

  // One-hot ALU select in {IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV}
  function automatic logic [13:0] alu_sel(input logic [4:0] o);
    case (o)
      5'd3:    alu_sel = 14'b01_0000_0000_0000; // ADD
      5'd4:    alu_sel = 14'b00_1000_0000_0000; // SUB
      5'd5:    alu_sel = 14'b00_0100_0000_0000; // AND
      5'd6:    alu_sel = 14'b00_0010_0000_0000; // OR
      5'd9:    alu_sel = 14'b00_0001_0000_0000; // SHR
      5'd10:   alu_sel = 14'b00_0000_1000_0000; // SHRA
      5'd11:   alu_sel = 14'b00_0000_0100_0000; // SHL
      5'd7:    alu_sel = 14'b00_0000_0010_0000; // ROR
      5'd8:    alu_sel = 14'b00_0000_0001_0000; // ROL
      5'd17:   alu_sel = 14'b00_0000_0000_1000; // NEG
      5'd18:   alu_sel = 14'b00_0000_0000_0100; // NOT
      5'd15:   alu_sel = 14'b00_0000_0000_0010; // MUL
      5'd16:   alu_sel = 14'b00_0000_0000_0001; // DIV
      default: alu_sel = 14'b0;
    endcase
  endfunction

  // Decode fields are captured from IR only on the T2->T3 edge
  always_comb begin
    opc_nx = opc;
    ra_nx  = ra;
    rb_nx  = rb;
    rc_nx  = rc;
    if (state == T2) begin
      opc_nx = IR[31:27];
      ra_nx  = IR[26:23];
      rb_nx  = IR[22:19];
      rc_nx  = IR[18:15];
    end
  end

  assign cls    = classify(opc);
  assign cls_nx = classify(opc_nx);

  // Next-state: fetch is common, execute length depends on the latched class
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = T0;
      T0:      state_nx = T1;
      T1:      state_nx = T2;
      T2:      state_nx = T3;
      T3:      state_nx = (cls == C_ILL) ? IDLE : T4;
      T4:      state_nx = (cls == C_UNA) ? IDLE : T5;
      T5:      state_nx = (cls == C_BIN) ? IDLE : T6;
      T6:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control word for the state being entered
  always_comb begin
    rin_nx     = '0;
    rout_nx    = '0;
    cin_nx     = '0;
    cout_nx    = '0;
    alu_nx     = '0;
    read_nx    = 1'b0;
    done_nx    = 1'b0;
    illegal_nx = 1'b0;
    busy_nx    = (state_nx != IDLE);
    case (state_nx)
      T0: begin
        cout_nx[CO_PC]   = 1'b1;
        cin_nx[CI_MAR]   = 1'b1;
        cin_nx[CI_Z]     = 1'b1;
        alu_nx[A_INCPC]  = 1'b1;
      end
      T1: begin
        cout_nx[CO_ZLO]  = 1'b1;
        cin_nx[CI_PC]    = 1'b1;
        cin_nx[CI_MDR]   = 1'b1;
        read_nx          = 1'b1;
      end
      T2: begin
        cout_nx[CO_MDR]  = 1'b1;
        cin_nx[CI_IR]    = 1'b1;
      end
      T3: begin
        case (cls_nx)
          C_BIN: begin rout_nx = 16'd1 << rb_nx; cin_nx[CI_Y] = 1'b1; end
          C_UNA: begin rout_nx = 16'd1 << rb_nx; alu_nx = alu_sel(opc_nx); cin_nx[CI_Z] = 1'b1; end
          C_MD:  begin rout_nx = 16'd1 << ra_nx; cin_nx[CI_Y] = 1'b1; end
          default: illegal_nx = 1'b1;
        endcase
      end
      T4: begin
        case (cls_nx)
          C_BIN: begin rout_nx = 16'd1 << rc_nx; alu_nx = alu_sel(opc_nx); cin_nx[CI_Z] = 1'b1; end
          C_MD:  begin rout_nx = 16'd1 << rb_nx; alu_nx = alu_sel(opc_nx); cin_nx[CI_Z] = 1'b1; end
          C_UNA: begin cout_nx[CO_ZLO] = 1'b1; rin_nx = 16'd1 << ra_nx; done_nx = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        cout_nx[CO_ZLO] = 1'b1;
        if (cls_nx == C_BIN) begin
          rin_nx  = 16'd1 << ra_nx;
          done_nx = 1'b1;
        end else begin
          cin_nx[CI_LO] = 1'b1;
        end
      end
      T6: begin
        cout_nx[CO_ZHI] = 1'b1;
        cin_nx[CI_HI]   = 1'b1;
        done_nx         = 1'b1;
      end
      default: ;
    endcase
  end

  // State and latched decode register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      opc   <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
    end else begin
      state <= state_nx;
      opc   <= opc_nx;
      ra    <= ra_nx;
      rb    <= rb_nx;
      rc    <= rc_nx;
    end
  end

  // Registered Moore outputs
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      Rin      <= '0;
      Rout     <= '0;
      ctrl_in  <= '0;
      ctrl_out <= '0;
      alu_op   <= '0;
      Read     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      Rin      <= rin_nx;
      Rout     <= rout_nx;
      ctrl_in  <= cin_nx;
      ctrl_out <= cout_nx;
      alu_op   <= alu_nx;
      Read     <= read_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      illegal  <= illegal_nx;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench. A reference model expands each
// accepted instruction into its per-cycle control words; a monitor pops one
// expected word per cycle and compares it with the DUT outputs.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] IR    = '0;
  logic [15:0] Rin, Rout;
  logic [7:0]  ctrl_in, ctrl_out;
  logic [13:0] alu_op;
  logic        Read, busy, done, illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .IR(IR),
    .Rin(Rin), .Rout(Rout), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
    .alu_op(alu_op), .Read(Read), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef logic [65:0] vec_t;
  vec_t dut_vec;
  assign dut_vec = {Rin, Rout, ctrl_in, ctrl_out, alu_op, Read, busy, done, illegal};

  int checks = 0;
  int errors = 0;

  vec_t q[$];
  int   m_pos = -1;
  int   m_len = 0;

  // Kinds: 0 illegal, 1 binary, 2 unary, 3 mul/div
  function automatic int op_bit(input logic [4:0] o);
    case (o)
      5'd3: return 12;  5'd4: return 11;  5'd5: return 10;  5'd6: return 9;
      5'd7: return 5;   5'd8: return 4;   5'd9: return 8;   5'd10: return 7;
      5'd11: return 6;  5'd15: return 1;  5'd16: return 0;  5'd17: return 3;
      5'd18: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int kind(input logic [4:0] o);
    if (op_bit(o) < 0) return 0;
    if (o == 5'd17 || o == 5'd18) return 2;
    if (o == 5'd15 || o == 5'd16) return 3;
    return 1;
  endfunction

  // Cycles from T0 through the last step
  function automatic int inst_len(input logic [31:0] ir);
    case (kind(ir[31:27]))
      1: return 6;
      2: return 5;
      3: return 7;
      default: return 4;
    endcase
  endfunction

  function automatic vec_t step_vec(input logic [31:0] ir, input int idx);
    logic [15:0] rin, rout;
    logic [7:0]  cin, cout;
    logic [13:0] alu;
    logic        rd, dn, il;
    int          k, ob, rel;
    rin = '0; rout = '0; cin = '0; cout = '0; alu = '0; rd = 0; dn = 0; il = 0;
    k   = kind(ir[31:27]);
    ob  = op_bit(ir[31:27]);
    rel = idx - 3;
    case (idx)
      0: begin cout[3] = 1; cin[1] = 1; cin[2] = 1; alu[13] = 1; end
      1: begin cout[4] = 1; cin[5] = 1; cin[0] = 1; rd = 1; end
      2: begin cout[2] = 1; cin[4] = 1; end
      default: begin
        if (k == 0) il = 1;
        else if (k == 1) begin
          if (rel == 0) begin rout[ir[22:19]] = 1; cin[3] = 1; end
          if (rel == 1) begin rout[ir[18:15]] = 1; alu[ob] = 1; cin[2] = 1; end
          if (rel == 2) begin cout[4] = 1; rin[ir[26:23]] = 1; dn = 1; end
        end else if (k == 2) begin
          if (rel == 0) begin rout[ir[22:19]] = 1; alu[ob] = 1; cin[2] = 1; end
          if (rel == 1) begin cout[4] = 1; rin[ir[26:23]] = 1; dn = 1; end
        end else begin
          if (rel == 0) begin rout[ir[26:23]] = 1; cin[3] = 1; end
          if (rel == 1) begin rout[ir[22:19]] = 1; alu[ob] = 1; cin[2] = 1; end
          if (rel == 2) begin cout[4] = 1; cin[6] = 1; end
          if (rel == 3) begin cout[5] = 1; cin[7] = 1; dn = 1; end
        end
      end
    endcase
    return {rin, rout, cin, cout, alu, rd, 1'b1, dn, il};
  endfunction

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: accepts start only when idle, expands the instruction
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      q.delete();
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (start) begin
        for (int i = 0; i < 3; i++) q.push_back(step_vec(32'h0, i));
        m_pos = 0;
        m_len = 3;
      end
    end else begin
      if (m_pos == 2) begin
        m_len = inst_len(IR);
        for (int i = 3; i < m_len; i++) q.push_back(step_vec(IR, i));
      end
      m_pos++;
      if (m_pos >= m_len) m_pos = -1;
    end
  end

  // Monitor: one expected word per cycle, idle word when nothing is pending
  always @(negedge clock) begin
    vec_t e;
    if (!clear) begin
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      chk("cycle", dut_vec, e);
      checks++;
      if ($countones({Rout, ctrl_out}) > 1) begin
        errors++;
        $display("FAIL bus_driver at %0t: actual=%h required=at most one bit", $time, {Rout, ctrl_out});
      end
      checks++;
      if ($countones(alu_op) > 1) begin
        errors++;
        $display("FAIL alu_onehot at %0t: actual=%h required=at most one bit", $time, alu_op);
      end
    end
  end

  task automatic pulse_clear();
    #1 clear = 1'b1;
    #1 chk("clear_async", dut_vec, '0);
    #1 clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_pos < 0 && q.size() == 0) && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    checks++;
    if (!(m_pos < 0 && q.size() == 0)) begin
      errors++;
      $display("FAIL idle_timeout: actual=busy after %0d cycles required=idle", n);
    end
    @(negedge clock);
  endtask

  task automatic run_inst(input logic [31:0] ir);
    @(negedge clock);
    IR    = ir;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] legal [13];
    logic [31:0] r;
    legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
    r = $urandom;
    if ($urandom_range(0, 99) < 85) r[31:27] = legal[$urandom_range(0, 12)];
    return r;
  endfunction

  initial begin
    #2 chk("reset_outputs", dut_vec, '0);
    repeat (2) @(negedge clock);
    chk("reset_hold", dut_vec, '0);
    clear = 1'b0;

    run_inst(32'h1A2B8000);   // ADD R4,R5,R7
    run_inst(32'h92380000);   // NOT R4,R7
    run_inst(32'h79980000);   // MUL R3,R3
    run_inst(32'hF8000000);   // illegal opcode 11111
    run_inst(32'h180B8000);   // ADD R0,R1,R7

    // abort during T4 of ADD
    @(negedge clock);
    IR = 32'h1A2B8000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10 && m_pos != 4; i++) @(negedge clock);
    pulse_clear();
    repeat (6) @(negedge clock);

    // start held high across whole instructions and done cycles
    @(negedge clock);
    IR = 32'h8A380000;        // NEG R4,R7
    start = 1'b1;
    repeat (14) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) IR = rand_ir();
      if ($urandom_range(0, 59) == 0) pulse_clear();
    end
    start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 clear  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  request to execute one instruction; sampled in IDLE only.
REQ-004 IR  in  32  instruction register contents from the datapath; decoded from T3 onward.
REQ-005 Rin  out  16  one-hot general-register load enables, R0..R15 (bit n = Rnin).
REQ-006 Rout  out  16  one-hot general-register bus drive enables, R0..R15.
REQ-007 ctrl_in  out  8  {HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin}.
REQ-008 ctrl_out  out  8  {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout}.
REQ-009 alu_op  out  14  one-hot {IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV}.
REQ-010 Read  out  1  memory read strobe into MDR.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse in the final step of a legal instruction.
REQ-013 illegal  out  1  one-cycle pulse when the opcode is undefined.

Function
REQ-014 All outputs shall be registered, Moore-style, as a function of the present state and latched decode only.
REQ-015 At most one bit of Rout and ctrl_out together shall be high in any cycle (single bus driver).
REQ-016 Decode fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
REQ-017 Opcodes:
- ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000
- SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000
- NEG 10001, NOT 10010
- all others are illegal.
REQ-018 States: IDLE, T0, T1, T2, T3, T4, T5, T6. IDLE -> T0 when start=1; otherwise remain in IDLE.
REQ-019 T0: PCout, MARin, IncPC, Zin.
REQ-020 T1: Zlowout, PCin, Read, MDRin.
REQ-021 T2: MDRout, IRin. The opcode, Ra, Rb and Rc fields shall be latched from IR at the T2->T3 edge.
REQ-022 Binary class (ADD..SHL):
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], op, Zin.
- T5: Zlowout, Rin[Ra], done -> IDLE.
REQ-023 Unary class (NEG, NOT):
- T3: Rout[Rb], op, Zin.
- T4: Zlowout, Rin[Ra], done -> IDLE.
REQ-024 MUL/DIV class:
- T3: Rout[Ra], Yin.
- T4: Rout[Rb], op, Zin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin, done -> IDLE.
REQ-025 Illegal opcode: T3 shall assert only illegal, with all other outputs 0, then go to IDLE; no register writes occur.
REQ-026 Latency from start to done: 6 cycles for binary, 5 for unary, 7 for MUL/DIV.
REQ-027 start asserted while busy shall be ignored; it shall not be queued.
REQ-028 start held high in the done cycle shall begin a new T0 only after one IDLE cycle.
REQ-029 Ra = 0 is a legal destination; Rin[0] shall be driven normally.

Reset
REQ-030 clear=1 shall force IDLE immediately and asynchronously, with every output 0 and the latched decode fields 0.
REQ-031 clear asserted mid-instruction shall abort it; no pending Rin, HIin or LOin shall assert afterwards.
REQ-032 After clear deasserts, the first T0 shall occur no earlier than the cycle after start is sampled high in IDLE.

Verification
REQ-033 ADD: IR=0x1A2B8000 (ADD R4,R5,R7), start pulse -> T3 Rout=0x0020 with Yin; T4 Rout=0x0080 with ADD and Zin; T5 Rin=0x0010 with done; 6 cycles total.
REQ-034 NOT: IR=0x92380000 (NOT R4,R7) -> T3 Rout=0x0080, NOT=1, Zin=1; T4 Zlowout=1, Rin=0x0010, done=1; back to IDLE in the next cycle.
REQ-035 MUL: IR=0x79980000 (MUL R3,R3 with Rb=R3) -> T5 Zlowout with LOin; T6 Zhighout with HIin and done; 7 cycles total; Rin=0 throughout.
REQ-036 Illegal: IR opcode 11111 -> illegal=1 at T3, Rin=0, HIin=0, LOin=0, done=0; IDLE next cycle.
REQ-037 Abort: clear pulsed during T4 of ADD -> all outputs 0 within the same cycle; Rin never equals 0x0010 afterwards.
REQ-038 Protocol checks on every cycle: one-hot bus driver, alu_op at most one bit set, and start during busy has no effect.
